// File: rtl/countdown_ctrl_if.sv
// Timer datapath link for countdown_ctrl.
// Carries the reload pulse, the count enable and the remaining seconds.
interface countdown_ctrl_if;
    logic       tmr_load;
    logic       tmr_en;
    logic [9:0] remain_sec;

    modport master (
        output tmr_load,
        output tmr_en,
        input  remain_sec
    );

    modport slave (
        input  tmr_load,
        input  tmr_en,
        output remain_sec
    );
endinterface

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: button conditioning and IDLE/RUN/PAUSE/ALARM/DONE sequencer.
// Macro TIMER_CTRL_WARN_EN: LED blinks in RUN while 0 < remain_sec <= WARN_SECS.
module countdown_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int DEB_MS     = 10,
    parameter int BLINK_HZ   = 2,
    parameter int ALARM_SECS = 5
`ifdef TIMER_CTRL_WARN_EN
    ,
    parameter int WARN_SECS  = 10
`endif
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       btn_clr,
    input  logic [3:0] sw,
    countdown_ctrl_if.master tmr,
    output logic [2:0] state,
    output logic       alarm,
    output logic       led
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        ALARM = 3'd3,
        DONE  = 3'd4
    } state_e;

    localparam int DEB_CYC = CLK_HZ / 1000 * DEB_MS;
    localparam int DW      = $clog2(DEB_CYC + 1);
    localparam int HALF    = CLK_HZ / (2 * BLINK_HZ);
    localparam int BW      = $clog2(HALF + 1);
    localparam int PW      = $clog2(CLK_HZ + 1);
    localparam int SW      = $clog2(ALARM_SECS + 2);
    localparam int SEC_M1  = (ALARM_SECS > 0) ? ALARM_SECS - 1 : 0;

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_M1);
    localparam bit            NO_ALARM  = (ALARM_SECS == 0);

    // Button conditioning: index 0 = start, index 1 = clr
    logic [1:0]         btn;
    logic [1:0]         s1_q, s2_q, deb_q, dly_q, press_q;
    logic [1:0][DW-1:0] dcnt_q;

    assign btn = {btn_clr, btn_start};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            dly_q   <= '0;
            press_q <= '0;
            dcnt_q  <= '0;
        end else begin
            s1_q    <= btn;
            s2_q    <= s1_q;
            dly_q   <= deb_q;
            press_q <= deb_q & ~dly_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] == deb_q[i]) begin
                    dcnt_q[i] <= '0;
                end else if (dcnt_q[i] == DEB_LAST) begin
                    deb_q[i]  <= s2_q[i];
                    dcnt_q[i] <= '0;
                end else begin
                    dcnt_q[i] <= dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic start_p, clr_p;
    assign start_p = press_q[0];
    assign clr_p   = press_q[1];

    state_e        state_q, state_d;
    logic [3:0]    sw_q;
    logic          first_q;
    logic          load_q, load_d;
    logic          en_q, en_d;
    logic          alarm_q, alarm_d;
    logic          led_q, led_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_q, blink_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [SW-1:0] secs_q, secs_d;
    logic          entry;
    logic          alarm_done;
    logic          expired;
    logic          win_start;
    logic          run_led;

    assign expired    = (tmr.remain_sec == 10'd0);
    assign alarm_done = NO_ALARM || (pre_q == PRE_LAST && secs_q == SEC_LAST);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_p && !clr_p && sw != 4'd0) state_d = RUN;
            RUN: begin
                if (clr_p)        state_d = IDLE;
                else if (expired) state_d = ALARM;
                else if (start_p) state_d = PAUSE;
            end
            PAUSE: begin
                if (clr_p)        state_d = IDLE;
                else if (start_p) state_d = RUN;
            end
            ALARM: begin
                if (clr_p)                      state_d = IDLE;
                else if (alarm_done || start_p) state_d = DONE;
            end
            DONE:    if (clr_p || start_p) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign entry = (state_d != state_q);

`ifdef TIMER_CTRL_WARN_EN
    localparam logic [9:0] WARN_LIM = 10'(WARN_SECS);
    logic win, win_q;

    assign win       = !expired && (tmr.remain_sec <= WARN_LIM);
    assign win_start = (state_d == RUN) && win && !win_q;
    assign run_led   = win ? blink_d : 1'b1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) win_q <= 1'b0;
        else       win_q <= win;
    end
`else
    assign win_start = 1'b0;
    assign run_led   = 1'b1;
`endif

    // Blink restarts high on every state entry
    always_comb begin
        bcnt_d  = bcnt_q + 1'b1;
        blink_d = blink_q;
        if (entry || win_start) begin
            bcnt_d  = '0;
            blink_d = 1'b1;
        end else if (bcnt_q == HALF_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
        end
    end

    always_comb begin
        pre_d  = '0;
        secs_d = '0;
        if (state_q == ALARM && !entry) begin
            if (pre_q == PRE_LAST) begin
                secs_d = secs_q + 1'b1;
            end else begin
                pre_d  = pre_q + 1'b1;
                secs_d = secs_q;
            end
        end
    end

    always_comb begin
        load_d  = first_q
               || (entry && state_d == IDLE)
               || (state_q == IDLE && state_d == IDLE && sw != sw_q);
        en_d    = (state_d == RUN);
        alarm_d = (state_d == ALARM) && blink_d;
        led_d   = 1'b0;
        unique case (state_d)
            IDLE:    led_d = 1'b0;
            RUN:     led_d = run_led;
            PAUSE:   led_d = blink_d;
            ALARM:   led_d = blink_d;
            DONE:    led_d = 1'b1;
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            sw_q    <= '0;
            first_q <= 1'b1;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            alarm_q <= 1'b0;
            led_q   <= 1'b0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            pre_q   <= '0;
            secs_q  <= '0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw;
            first_q <= 1'b0;
            load_q  <= load_d;
            en_q    <= en_d;
            alarm_q <= alarm_d;
            led_q   <= led_d;
            bcnt_q  <= bcnt_d;
            blink_q <= blink_d;
            pre_q   <= pre_d;
            secs_q  <= secs_d;
        end
    end

    assign tmr.tmr_load = load_q;
    assign tmr.tmr_en   = en_q;
    assign state        = state_q;
    assign alarm        = alarm_q;
    assign led          = led_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed bench for countdown_ctrl: CLK_HZ=1000, DEB_CYC=2, 250-cycle blink half-period,
// 1000-cycle second, ALARM_SECS=5.
module tb_countdown_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_clr = 1'b0;
    logic [3:0] sw = 4'd3;
    logic [2:0] state;
    logic       alarm;
    logic       led;

    int n_chk = 0;
    int n_fail = 0;
    int load_cnt = 0;

    countdown_ctrl_if tmr_if();

    countdown_ctrl #(
        .CLK_HZ    (1000),
        .DEB_MS    (2),
        .BLINK_HZ  (2),
        .ALARM_SECS(5)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_start(btn_start),
        .btn_clr  (btn_clr),
        .sw       (sw),
        .tmr      (tmr_if),
        .state    (state),
        .alarm    (alarm),
        .led      (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (tmr_if.tmr_load === 1'b1) load_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_wait(input bit s, input bit c, input logic [2:0] exp);
        btn_start = s;
        btn_clr   = c;
        for (int k = 0; k < 12 && state !== exp; k++) tick(1);
        btn_start = 1'b0;
        btn_clr   = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        sw = 4'd3;
        tmr_if.remain_sec = 10'd180;
        tick(3);
        n_chk++;
        if ({state, tmr_if.tmr_load, tmr_if.tmr_en, alarm, led} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {state, tmr_if.tmr_load, tmr_if.tmr_en, alarm, led});
        end
        #2 rstn = 1'b1;
        tick(1);
        n_chk++;
        if (tmr_if.tmr_load !== 1'b1 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_load_pulse: load=%b state=%0d required 1/0",
                     tmr_if.tmr_load, state);
        end
        tick(1);
        n_chk++;
        if (tmr_if.tmr_load !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_load_one_cycle: load=%b required 0", tmr_if.tmr_load);
        end
    endtask

    task automatic test_start;
        btn_start = 1'b1;
        tick(5);
        n_chk++;
        if (state !== 3'd0) begin
            n_fail++;
            $display("FAIL start_not_early: state=%0d required 0", state);
        end
        tick(1);
        n_chk++;
        if (state !== 3'd1 || tmr_if.tmr_en !== 1'b1 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL start_run: state=%0d en=%b led=%b required 1/1/1",
                     state, tmr_if.tmr_en, led);
        end
        tick(4);
        btn_start = 1'b0;
        tick(10);
        btn_start = 1'b1;
        tick(1);
        btn_start = 1'b0;
        tick(12);
        n_chk++;
        if (state !== 3'd1) begin
            n_fail++;
            $display("FAIL glitch_ignored: state=%0d required 1", state);
        end
    endtask

    task automatic test_pause;
        int l0;
        l0 = load_cnt;
        press_wait(1'b1, 1'b0, 3'd2);
        n_chk++;
        if (state !== 3'd2 || tmr_if.tmr_en !== 1'b0 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_entry: state=%0d en=%b led=%b required 2/0/1",
                     state, tmr_if.tmr_en, led);
        end
        tick(249);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_led_high: led=%b required 1", led);
        end
        tick(1);
        n_chk++;
        if (led !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_led_toggle: led=%b required 0", led);
        end
        tick(250);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_led_retoggle: led=%b required 1", led);
        end
        tick(8);
        press_wait(1'b1, 1'b0, 3'd1);
        n_chk++;
        if (state !== 3'd1 || tmr_if.tmr_en !== 1'b1 || load_cnt !== l0) begin
            n_fail++;
            $display("FAIL resume: state=%0d en=%b loads=%0d required 1/1/%0d",
                     state, tmr_if.tmr_en, load_cnt, l0);
        end
        tick(8);
    endtask

    task automatic test_expiry;
        tmr_if.remain_sec = 10'd0;
        tick(1);
        n_chk++;
        if ({state, tmr_if.tmr_en, alarm, led} !== {3'd3, 3'b011}) begin
            n_fail++;
            $display("FAIL alarm_entry: got %b required 011011",
                     {state, tmr_if.tmr_en, alarm, led});
        end
        tick(249);
        n_chk++;
        if (alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_high: alarm=%b required 1", alarm);
        end
        tick(1);
        n_chk++;
        if (alarm !== 1'b0 || led !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_toggle: alarm=%b led=%b required 0/0", alarm, led);
        end
        tick(4749);
        n_chk++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL alarm_hold: state=%0d required 3", state);
        end
        tick(1);
        n_chk++;
        if (state !== 3'd4 || alarm !== 1'b0 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_timeout_done: state=%0d alarm=%b led=%b required 4/0/1",
                     state, alarm, led);
        end
        press_wait(1'b1, 1'b0, 3'd0);
        n_chk++;
        if (state !== 3'd0 || tmr_if.tmr_load !== 1'b1) begin
            n_fail++;
            $display("FAIL done_to_idle: state=%0d load=%b required 0/1",
                     state, tmr_if.tmr_load);
        end
        tick(1);
        n_chk++;
        if (tmr_if.tmr_load !== 1'b0) begin
            n_fail++;
            $display("FAIL done_load_one_cycle: load=%b required 0", tmr_if.tmr_load);
        end
        tmr_if.remain_sec = 10'd180;
        tick(8);
    endtask

    task automatic test_alarm_ack;
        press_wait(1'b1, 1'b0, 3'd1);
        tick(8);
        tmr_if.remain_sec = 10'd0;
        tick(9);
        press_wait(1'b1, 1'b0, 3'd4);
        n_chk++;
        if (state !== 3'd4 || alarm !== 1'b0 || led !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_ack: state=%0d alarm=%b led=%b required 4/0/1",
                     state, alarm, led);
        end
        tmr_if.remain_sec = 10'd180;
        tick(8);
        press_wait(1'b0, 1'b1, 3'd0);
        n_chk++;
        if (state !== 3'd0 || tmr_if.tmr_load !== 1'b1 || tmr_if.tmr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL done_clr: state=%0d load=%b en=%b required 0/1/0",
                     state, tmr_if.tmr_load, tmr_if.tmr_en);
        end
        tick(8);
    endtask

    task automatic test_back_to_back;
        press_wait(1'b1, 1'b0, 3'd1);
        tick(8);
        press_wait(1'b1, 1'b1, 3'd0);
        n_chk++;
        if (state !== 3'd0 || tmr_if.tmr_load !== 1'b1 || tmr_if.tmr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clr_same: state=%0d load=%b en=%b required 0/1/0",
                     state, tmr_if.tmr_load, tmr_if.tmr_en);
        end
        tick(1);
        sw = 4'd0;
        tick(1);
        n_chk++;
        if (tmr_if.tmr_load !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_change_load: load=%b required 1", tmr_if.tmr_load);
        end
        tick(1);
        n_chk++;
        if (tmr_if.tmr_load !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_change_one_cycle: load=%b required 0", tmr_if.tmr_load);
        end
        tick(6);
        btn_start = 1'b1;
        tick(10);
        btn_start = 1'b0;
        n_chk++;
        if (state !== 3'd0 || tmr_if.tmr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_zero_start: state=%0d en=%b required 0/0",
                     state, tmr_if.tmr_en);
        end
        tick(8);
        sw = 4'd3;
        tick(4);
    endtask

    task automatic test_warn;
        press_wait(1'b1, 1'b0, 3'd1);
        tmr_if.remain_sec = 10'd11;
        tick(2);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL warn_outside: led=%b required 1", led);
        end
        tmr_if.remain_sec = 10'd10;
`ifdef TIMER_CTRL_WARN_EN
        tick(250);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL warn_first_half: led=%b required 1", led);
        end
        tick(1);
        n_chk++;
        if (led !== 1'b0) begin
            n_fail++;
            $display("FAIL warn_blink: led=%b required 0", led);
        end
        tmr_if.remain_sec = 10'd11;
        tick(1);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL warn_exit: led=%b required 1", led);
        end
`else
        tick(251);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL no_warn_led_a: led=%b required 1", led);
        end
        tick(250);
        n_chk++;
        if (led !== 1'b1) begin
            n_fail++;
            $display("FAIL no_warn_led_b: led=%b required 1", led);
        end
`endif
        tmr_if.remain_sec = 10'd180;
        tick(2);
    endtask

    task automatic test_reset_mid;
        #2 rstn = 1'b0;
        #1;
        n_chk++;
        if ({state, tmr_if.tmr_load, tmr_if.tmr_en, alarm, led} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b required 0000000",
                     {state, tmr_if.tmr_load, tmr_if.tmr_en, alarm, led});
        end
        tick(2);
        rstn = 1'b1;
        tick(4);
    endtask

    initial begin
        tmr_if.remain_sec = 10'd180;
        test_reset();
        test_start();
        test_pause();
        test_expiry();
        test_alarm_ack();
        test_back_to_back();
        test_warn();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
